// File: rtl/poly_unpack12.sv
// ByteDecode12 unpacker: 3 bytes -> two mod-q 12-bit coefficients, written as a pair 1 cycle after the 3rd byte.
// One byte per cycle when in_valid is held; in_valid low stalls in place, in_ready is low outside byte-intake states.
module poly_unpack12 #(
  parameter int N         = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        w1_en,
  output logic [15:0] w1_addr,
  output logic [15:0] w1_d,
  output logic        w2_en,
  output logic [15:0] w2_addr,
  output logic [15:0] w2_d,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [15:0] K_LAST = 16'(N / 2 - 1);
  localparam logic [15:0] BASE   = 16'(BASE_ADDR);
  localparam logic [11:0] Q      = 12'd3329;

  state_t      state, state_nxt;
  logic [7:0]  b0_q, b1_q;
  logic [15:0] k_q;
  logic        xfer;
  logic        group_done;
  logic [11:0] c0, c1, c0_red, c1_red;
  logic        c0_big, c1_big;

  assign xfer       = in_valid && in_ready;
  assign group_done = xfer && (state == S_B2);

  // The third byte is consumed straight off the bus; only b0/b1 are held.
  assign c0     = {b1_q[3:0], b0_q};
  assign c1     = {in_data, b1_q[7:4]};
  assign c0_big = (c0 >= Q);
  assign c1_big = (c1 >= Q);
  assign c0_red = c0_big ? (c0 - Q) : c0;
  assign c1_red = c1_big ? (c1 - Q) : c1;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_B0;
      end
      S_B0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = S_B1;
      end
      S_B1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = S_B2;
      end
      S_B2: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = (k_q == K_LAST) ? S_FLUSH : S_B0;
      end
      S_FLUSH: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      b0_q    <= 8'h00;
      b1_q    <= 8'h00;
      k_q     <= 16'h0000;
      err     <= 1'b0;
      w1_en   <= 1'b0;
      w2_en   <= 1'b0;
      w1_addr <= 16'h0000;
      w2_addr <= 16'h0000;
      w1_d    <= 16'h0000;
      w2_d    <= 16'h0000;
    end else begin
      state <= state_nxt;
      w1_en <= group_done;
      w2_en <= group_done;
      if (xfer && (state == S_B0)) b0_q <= in_data;
      if (xfer && (state == S_B1)) b1_q <= in_data;
      if ((state == S_IDLE) && start) begin
        k_q <= 16'h0000;
        err <= 1'b0;
      end else if (group_done) begin
        // Address math is 16-bit and wraps; pair k lands at even/odd slots 2k, 2k+1.
        w1_addr <= BASE + {k_q[14:0], 1'b0};
        w2_addr <= BASE + {k_q[14:0], 1'b1};
        w1_d    <= {4'h0, c0_red};
        w2_d    <= {4'h0, c1_red};
        err     <= err | c0_big | c1_big;
        k_q     <= k_q + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_poly_unpack12.sv
// Bench for poly_unpack12: N=2 vector table plus randomized N=256 runs against an arithmetic reference.
module tb_poly_unpack12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // N=256, BASE_ADDR=0x100 instance
  logic        start, in_valid, in_ready, w1_en, w2_en, busy, done, err;
  logic [7:0]  in_data;
  logic [15:0] w1_addr, w2_addr, w1_d, w2_d;

  // N=2, BASE_ADDR=0 instance
  logic        s2_start, s2_valid, s2_ready, s2_w1_en, s2_w2_en, s2_busy, s2_done, s2_err;
  logic [7:0]  s2_data;
  logic [15:0] s2_w1_addr, s2_w2_addr, s2_w1_d, s2_w2_d;

  poly_unpack12 #(.N(256), .BASE_ADDR(16'h100)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w1_en(w1_en), .w1_addr(w1_addr), .w1_d(w1_d),
    .w2_en(w2_en), .w2_addr(w2_addr), .w2_d(w2_d), .busy(busy), .done(done), .err(err)
  );

  poly_unpack12 #(.N(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(s2_start), .in_valid(s2_valid), .in_data(s2_data),
    .in_ready(s2_ready), .w1_en(s2_w1_en), .w1_addr(s2_w1_addr), .w1_d(s2_w1_d),
    .w2_en(s2_w2_en), .w2_addr(s2_w2_addr), .w2_d(s2_w2_d), .busy(s2_busy), .done(s2_done),
    .err(s2_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic e1, e2;
    logic [15:0] a1, a2, d1, d2;
    logic er;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] ram [0:65535];
  int          done_cnt = 0;

  // Captures every write of the N=256 instance and mirrors it into a RAM model.
  always @(negedge clk) begin
    if (reset && (w1_en || w2_en)) begin
      wq.push_back('{w1_en, w2_en, w1_addr, w2_addr, w1_d, w2_d, err});
      if (w1_en) ram[w1_addr] = w1_d;
      if (w2_en) ram[w2_addr] = w2_d;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          gap;
    logic [15:0] e1, e2;
    logic        eerr;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] bs[3];
    bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2;
    @(negedge clk);
    s2_start = 1'b1; s2_valid = 1'b1; s2_data = 8'hAA;  // offered in IDLE, must not be taken
    @(negedge clk);
    s2_start = 1'b0;
    chk($sformatf("v%0d_busy", idx), s2_busy, 1);
    chk($sformatf("v%0d_rdy", idx), s2_ready, 1);
    chk($sformatf("v%0d_err_clr", idx), s2_err, 0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        for (int g = 0; g < v.gap; g++) begin
          s2_valid = 1'b0; s2_data = 8'($urandom);
          @(negedge clk);
          chk($sformatf("v%0d_stall_rdy", idx), s2_ready, 1);
          chk($sformatf("v%0d_stall_wen", idx), s2_w1_en | s2_w2_en, 0);
        end
      end
      s2_valid = 1'b1; s2_data = bs[i];
      @(negedge clk);
      if (i < 2) chk($sformatf("v%0d_wen_early", idx), s2_w1_en | s2_w2_en, 0);
    end
    s2_valid = 1'b1; s2_data = 8'h55;
    chk($sformatf("v%0d_w1_en", idx), s2_w1_en, 1);
    chk($sformatf("v%0d_w2_en", idx), s2_w2_en, 1);
    chk($sformatf("v%0d_w1_addr", idx), s2_w1_addr, 0);
    chk($sformatf("v%0d_w2_addr", idx), s2_w2_addr, 1);
    chk($sformatf("v%0d_w1_d", idx), s2_w1_d, v.e1);
    chk($sformatf("v%0d_w2_d", idx), s2_w2_d, v.e2);
    chk($sformatf("v%0d_err", idx), s2_err, v.eerr);
    chk($sformatf("v%0d_flush_rdy", idx), s2_ready, 0);
    chk($sformatf("v%0d_flush_done", idx), s2_done, 0);
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), s2_done, 1);
    chk($sformatf("v%0d_done_busy", idx), s2_busy, 0);
    chk($sformatf("v%0d_done_wen", idx), s2_w1_en | s2_w2_en, 0);
    chk($sformatf("v%0d_hold_d", idx), s2_w1_d, v.e1);
    chk($sformatf("v%0d_err_stable", idx), s2_err, v.eerr);
    s2_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), s2_done, 0);
  endtask

  logic [7:0] pb[384];

  task automatic run_poly(input string tag, input bit rnd_valid, input bit noise, input int abort_at);
    int acc, cyc, d0, last_wr, nw, c0, c1;
    logic eacc;
    int expc[256];
    for (int i = 0; i < 384; i++) pb[i] = 8'($urandom);
    for (int i = 16'h100; i < 16'h200; i++) ram[i] = 16'hFFFF;
    wq.delete();
    acc = 0; last_wr = -1; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    chk({tag, "_busy0"}, busy, 1);
    chk({tag, "_rdy0"}, in_ready, 1);
    chk({tag, "_err0"}, err, 0);
    while (cyc < 4000) begin
      if (done) break;
      if (abort_at > 0 && acc == abort_at) begin
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk({tag, "_rst_rdy"}, in_ready, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_err"}, err, 0);
        chk({tag, "_rst_wen"}, {w1_en, w2_en}, 0);
        chk({tag, "_rst_addr"}, {w1_addr, w2_addr}, 0);
        chk({tag, "_rst_d"}, {w1_d, w2_d}, 0);
        nw = wq.size();
        chk({tag, "_pre_rst_writes"}, nw, abort_at / 3);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk({tag, "_post_rst_writes"}, wq.size(), nw);
        chk({tag, "_post_rst_done"}, done_cnt, d0);
        chk({tag, "_post_rst_busy"}, busy, 0);
        return;
      end
      chk({tag, "_rdy_only_busy"}, in_ready & ~busy, 0);
      start = noise && ($urandom_range(5) == 0);
      if (w1_en && w1_addr == 16'h1FE) begin
        last_wr = cyc;
        chk({tag, "_flush_rdy"}, in_ready, 0);
        chk({tag, "_flush_busy"}, busy, 1);
        if (noise) start = 1'b1;
      end
      in_valid = rnd_valid ? 1'($urandom) : 1'b1;
      in_data  = (acc < 384) ? pb[acc] : 8'($urandom);
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (cyc >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", tag, cyc);
    end
    if (!rnd_valid) begin
      chk({tag, "_done_cycle"}, cyc, 386);
      chk({tag, "_flush_cycle"}, last_wr, 385);
    end
    chk({tag, "_bytes"}, acc, 384);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_nwrites"}, wq.size(), 128);
    eacc = 1'b0;
    for (int j = 0; j < 128; j++) begin
      c0 = pb[3*j] + 256 * (pb[3*j+1] % 16);
      c1 = pb[3*j+1] / 16 + 16 * pb[3*j+2];
      eacc = eacc | (c0 >= 3329) | (c1 >= 3329);
      expc[2*j]   = c0 % 3329;
      expc[2*j+1] = c1 % 3329;
      if (j < wq.size()) begin
        chk($sformatf("%s_wen%0d", tag, j), {wq[j].e1, wq[j].e2}, 2'b11);
        chk($sformatf("%s_a1_%0d", tag, j), wq[j].a1, 16'h100 + 2*j);
        chk($sformatf("%s_a2_%0d", tag, j), wq[j].a2, 16'h100 + 2*j + 1);
        chk($sformatf("%s_d1_%0d", tag, j), wq[j].d1, expc[2*j]);
        chk($sformatf("%s_d2_%0d", tag, j), wq[j].d2, expc[2*j+1]);
        chk($sformatf("%s_err_%0d", tag, j), wq[j].er, eacc);
      end
    end
    chk({tag, "_err_final"}, err, eacc);
    for (int i = 0; i < 256; i++) chk($sformatf("%s_ram%0d", tag, i), ram[16'h100 + i], expc[i]);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, done_cnt, d0 + 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rdy"}, in_ready, 0);
  endtask

  initial begin
    vt[0] = '{8'h01, 8'h23, 8'h45, 0, 16'h0301, 16'h0452, 1'b0};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 0, 16'd766,  16'd766,  1'b1};
    vt[2] = '{8'h01, 8'hFD, 8'hD0, 2, 16'd0,    16'd14,   1'b1};
    vt[3] = '{8'h00, 8'h0D, 8'h00, 1, 16'd3328, 16'd0,    1'b0};
    vt[4] = '{8'h00, 8'hD0, 8'hD0, 0, 16'd0,    16'd12,   1'b1};
    vt[5] = '{8'h34, 8'h12, 8'hAB, 3, 16'h0234, 16'h0AB1, 1'b0};

    start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s2_start = 1'b0; s2_valid = 1'b0; s2_data = 8'h00;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {in_ready, s2_ready}, 0);
    chk("rst_wen", {w1_en, w2_en, s2_w1_en, s2_w2_en}, 0);
    chk("rst_busy_done_err", {busy, done, err, s2_busy, s2_done, s2_err}, 0);
    chk("rst_addr", {w1_addr, w2_addr}, 0);
    chk("rst_d", {w1_d, w2_d}, 0);
    chk("rst_n2_addr_d", {s2_w1_addr, s2_w2_addr, s2_w1_d, s2_w2_d}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_rdy", in_ready, 0);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

    run_poly("nostall", 1'b0, 1'b0, 0);
    run_poly("rnd_a", 1'b1, 1'b1, 0);
    run_poly("rnd_b", 1'b1, 1'b1, 0);
    run_poly("abort", 1'b0, 1'b0, 100);
    run_poly("after_abort", 1'b1, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_unpack12.md
# poly_unpack12

Byte-stream unpacker for Kyber ByteDecode12. It accepts a valid/ready byte stream, assembles each 3-byte group into two 12-bit coefficients, and reduces any coefficient ≥ q = 3329. It writes both coefficients in one cycle through the two write ports of `poly_ram`. It sits directly upstream of `poly_ram` and fills one polynomial per `start`.

## Interface
- `N`, default 256: coefficients per polynomial. Must be even and ≥ 2.
- `BASE_ADDR`, default 0: RAM address of coefficient 0.
- `clk` input, 1 bit: clock, rising-edge.
- `reset` input, 1 bit: asynchronous, active-low reset (0 = reset).
- `start` input, 1 bit: begin unpacking one polynomial. Sampled only in IDLE.
- `in_valid` input, 1 bit: byte available.
- `in_data` input, 8 bits: stream byte.
- `in_ready` output, 1 bit: unpacker accepts a byte. A transfer occurs when `in_valid && in_ready` at a rising edge.
- `w1_en` output, 1 bit: write strobe for even coefficient (connects to `poly_ram.w1_en`).
- `w1_addr` output, 16 bits: even coefficient address.
- `w1_d` output, 16 bits: even coefficient value (connects to `poly_ram.d1_in`).
- `w2_en` output, 1 bit: write strobe for odd coefficient.
- `w2_addr` output, 16 bits: odd coefficient address.
- `w2_d` output, 16 bits: odd coefficient value (connects to `poly_ram.d2_in`).
- `busy` output, 1 bit: high from the cycle after an accepted `start` through the cycle before `done`.
- `done` output, 1 bit: one-cycle pulse when the polynomial is complete.
- `err` output, 1 bit: sticky. Set if any coefficient of the current polynomial was ≥ 3329. Cleared by `start`.

## Operation
- States:
  - IDLE
  - B0, B1, B2: waiting for byte 0, 1 and 2 of a group.
  - FLUSH: final write pending.
  - DONE
- IDLE:
  - `start = 1` clears the pair counter k and `err`.
  - Next state is B0.
- B0 → B1 → B2 advance only on a byte transfer. The unpacker holds b0 and b1 in registers.
- On the B2 transfer, with bytes b0, b1, b2:
  - c0 = {b1[3:0], b0}
  - c1 = {b2, b1[7:4]}
- Reduction: ci' = ci − 3329 if ci ≥ 3329, else ci. One subtraction suffices because the maximum is 4095.
  - The error flag is set if either coefficient needs reduction.
  - Data outputs are zero-extended to 16 bits.
- Write in the cycle after the B2 transfer:
  - `w1_en = w2_en = 1`.
  - `w1_addr = BASE_ADDR + 2k`, `w2_addr = BASE_ADDR + 2k + 1`.
  - `w1_d = c0'`, `w2_d = c1'`.
  - k then increments.
- If k < N/2 − 1 at the B2 transfer, the next state is B0. Byte intake continues with no bubble.
- If k = N/2 − 1, the next state is FLUSH. `in_ready` drops.
- FLUSH → DONE → IDLE unconditionally.
- `in_ready` = 1 exactly in states B0, B1 and B2.
- `start` is ignored outside IDLE. Bytes are never accepted in IDLE, FLUSH or DONE.
- Address arithmetic is 16-bit and wraps modulo 2^16.
- `w*_en` is low in every cycle without a write. `w*_addr` and `w*_d` hold their last written values.

## Timing
- Reset (`reset = 0`), asynchronous:
  - State goes to IDLE; k = 0.
  - `in_ready`, `w1_en`, `w2_en`, `busy`, `done` and `err` are 0.
  - `w1_addr`, `w2_addr`, `w1_d` and `w2_d` are 0.
- Reset mid-polynomial aborts the polynomial. No further writes occur and `done` is not pulsed. Partially written RAM contents are left as they are.
- `start` high at edge t0: `busy` and `in_ready` are 1 from cycle t0+1.
- Write latency: strobes assert exactly 1 cycle after the edge that accepts the third byte of a group.
- Throughput: one byte per cycle when `in_valid` is held high, giving 2 coefficients per 3 cycles.
- With no stalls, N = 256 takes 384 bytes:
  - Bytes at cycles 1–384.
  - Last write (FLUSH) at cycle 385.
  - `done` = 1 and `busy` = 0 at cycle 386.
- `in_valid` low in any B-state stalls the unpacker with no state change.
- `err` updates in the same cycle as the write that caused it. It is stable when `done` pulses.

## Test plan
- N = 2, start, then bytes 0x01, 0x23, 0x45 back-to-back:
  - One write with w1 = 0x0301 @ 0 and w2 = 0x0452 @ 1.
  - `done` pulses 2 cycles after the third byte.
  - `err` = 0.
- N = 2, bytes 0xFF, 0xFF, 0xFF → w1_d = 766, w2_d = 766, `err` = 1.
- N = 2, bytes 0x01, 0xFD, 0xD0 (c0 = 3329, c1 = 3343) → w1_d = 0, w2_d = 14, `err` = 1. A following start with valid bytes clears `err`.
- N = 256, BASE_ADDR = 0x100, random bytes with `in_valid` toggled randomly:
  - 128 write pairs at 0x100–0x1FF, matching a reference model.
  - No byte is accepted outside B-states.
  - Readback through `poly_ram` matches.
- N = 256, assert `reset` = 0 after 100 bytes:
  - All outputs are 0 immediately and no `done` pulses.
  - A new start then completes normally with k restarting at 0.
- `start` pulsed while busy and during FLUSH → ignored. `done` count stays at 1 and addresses stay contiguous.
